// File: rtl/snoop_write_port_if.sv
// rtl/snoop_write_port_if.sv - bus bundle between the snoop write port and its environment
//
// Groups the forwarded-store input, the local pipeline status, the DMEM snoop
// write port and the status flags. The slave modport is the snoop_write_port
// view; the master modport is the view of whatever drives it (coherency
// controller plus local pipeline).
//   ext*         forwarded store from the other core (one-cycle valid pulse)
//   locWren      local pipeline DMEM write this cycle (priority over snoop)
//   locRd*       local MEM-stage load address/valid for hit detection
//   mem*         registered snoop write to the local DMEM port
//   rdHit        local load word matches a pending entry
//   forceStall   request that the local pipeline freeze so the FIFO drains
//   busy         FIFO non-empty
//   errFlag      sticky overflow / misaligned / illegal-funct3 error
interface snoop_write_port_if;
    logic [31:0] extAddr;
    logic [31:0] extData;
    logic [2:0]  extFunct3;
    logic        extWren;
    logic        locWren;
    logic [31:0] locRdAddr;
    logic        locRden;
    logic        memWren;
    logic [29:0] memAddr;
    logic [3:0]  memByteEn;
    logic [31:0] memData;
    logic        rdHit;
    logic        forceStall;
    logic        busy;
    logic        errFlag;

    modport master (
        output extAddr, extData, extFunct3, extWren,
        output locWren, locRdAddr, locRden,
        input  memWren, memAddr, memByteEn, memData,
        input  rdHit, forceStall, busy, errFlag
    );

    modport slave (
        input  extAddr, extData, extFunct3, extWren,
        input  locWren, locRdAddr, locRden,
        output memWren, memAddr, memByteEn, memData,
        output rdHit, forceStall, busy, errFlag
    );
endinterface

// File: rtl/snoop_write_port.sv
// rtl/snoop_write_port.sv - receive side of the inter-core store broadcast
//
// Queues stores forwarded from the other core, converts each to a byte-enabled
// word write at push time, and drains the queue into the local DMEM write port
// on cycles where the local pipeline is not writing. If draining is blocked for
// STARVE_MAX cycles the block raises forceStall until the queue is empty.
// Ports:
//   clk    core clock (posedge only)
//   reset  asynchronous, active-high; clears all state
//   bus    snoop_write_port_if.slave (see interface file for signal list)
module snoop_write_port #(
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 8
) (
    input logic               clk,
    input logic               reset,
    snoop_write_port_if.slave bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRAIN,
        ST_FORCE
    } state_t;

    // Entry storage; contents are only meaningful between the pointers, so it
    // needs no reset.
    logic [29:0] r_addr_q [DEPTH];
    logic [3:0]  r_be_q   [DEPTH];
    logic [31:0] r_data_q [DEPTH];

    // Extra MSB distinguishes full from empty when the index bits match.
    logic [AW:0]   r_wr_ptr;
    logic [AW:0]   r_rd_ptr;
    logic [CW-1:0] r_starve;
    state_t        r_state;
    logic          r_force;
    logic          r_err;
    logic          r_mem_wren;
    logic [29:0]   r_mem_addr;
    logic [3:0]    r_mem_be;
    logic [31:0]   r_mem_data;

    logic          w_legal_f3;
    logic          w_misalign;
    logic [3:0]    w_be;
    logic [31:0]   w_wdata;
    logic          w_push_req;
    logic          w_bad;
    logic          w_empty;
    logic          w_full;
    logic          w_pop;
    logic          w_push;
    logic          w_ovf;
    logic [AW:0]   w_count;
    logic [AW-1:0] w_off;
    logic          w_hit;
    logic          w_unused;

    // Lane formation and legality of the incoming store.
    always_comb begin
        w_legal_f3 = 1'b1;
        w_misalign = 1'b0;
        w_be       = 4'b0000;
        w_wdata    = 32'h0;
        case (bus.extFunct3)
            3'b000: begin
                w_be    = 4'b0001 << bus.extAddr[1:0];
                w_wdata = {4{bus.extData[7:0]}};
            end
            3'b001: begin
                w_be       = bus.extAddr[1] ? 4'b1100 : 4'b0011;
                w_wdata    = {2{bus.extData[15:0]}};
                w_misalign = bus.extAddr[0];
            end
            3'b010: begin
                w_be       = 4'b1111;
                w_wdata    = bus.extData;
                w_misalign = |bus.extAddr[1:0];
            end
            default: w_legal_f3 = 1'b0;
        endcase
    end

    assign w_push_req = bus.extWren & w_legal_f3 & ~w_misalign;
    assign w_bad      = bus.extWren & (~w_legal_f3 | w_misalign);

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_count = r_wr_ptr - r_rd_ptr;

    // No bypass: an empty FIFO never pops, even when a push lands this edge.
    assign w_pop  = ~w_empty & ~bus.locWren;
    // A same-edge pop frees the slot a full FIFO needs for the push.
    assign w_push = w_push_req & (~w_full | w_pop);
    assign w_ovf  = w_push_req & w_full & ~w_pop;

    // Pending-entry hit: an entry is valid when its distance from the read
    // pointer is below the occupancy.
    always_comb begin
        w_hit = 1'b0;
        w_off = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_off = AW'(i) - r_rd_ptr[AW-1:0];
            if (({1'b0, w_off} < w_count) && (r_addr_q[i] == bus.locRdAddr[31:2]))
                w_hit = 1'b1;
        end
    end

    assign w_unused = &{1'b0, bus.locRdAddr[1:0]};

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_addr_q[r_wr_ptr[AW-1:0]] <= bus.extAddr[31:2];
            r_be_q[r_wr_ptr[AW-1:0]]   <= w_be;
            r_data_q[r_wr_ptr[AW-1:0]] <= w_wdata;
        end
    end

    // Pointers, error flag and the registered DMEM write port.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_err      <= 1'b0;
            r_mem_wren <= 1'b0;
            r_mem_addr <= '0;
            r_mem_be   <= '0;
            r_mem_data <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + {{AW{1'b0}}, 1'b1};
            if (w_bad | w_ovf)
                r_err <= 1'b1;
            r_mem_wren <= w_pop;
            if (w_pop) begin
                r_rd_ptr   <= r_rd_ptr + {{AW{1'b0}}, 1'b1};
                r_mem_addr <= r_addr_q[r_rd_ptr[AW-1:0]];
                r_mem_be   <= r_be_q[r_rd_ptr[AW-1:0]];
                r_mem_data <= r_data_q[r_rd_ptr[AW-1:0]];
            end
        end
    end

    // Starvation FSM: counts blocked cycles while draining and escalates to a
    // pipeline stall once the limit is reached.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_starve <= '0;
            r_force  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_starve <= '0;
                    r_force  <= 1'b0;
                    if (!w_empty)
                        r_state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (w_empty) begin
                        r_state  <= ST_IDLE;
                        r_starve <= '0;
                    end else if (w_pop) begin
                        r_starve <= '0;
                    end else if (bus.locWren) begin
                        r_starve <= r_starve + CW'(1);
                        if (r_starve == CW'(STARVE_MAX - 1)) begin
                            r_state <= ST_FORCE;
                            r_force <= 1'b1;
                        end
                    end
                end
                ST_FORCE: begin
                    if (w_empty) begin
                        r_state  <= ST_IDLE;
                        r_starve <= '0;
                        r_force  <= 1'b0;
                    end
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_starve <= '0;
                    r_force  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.memWren    = r_mem_wren;
    assign bus.memAddr    = r_mem_addr;
    assign bus.memByteEn  = r_mem_be;
    assign bus.memData    = r_mem_data;
    assign bus.rdHit      = bus.locRden & w_hit;
    assign bus.forceStall = r_force;
    assign bus.busy       = ~w_empty;
    assign bus.errFlag    = r_err;

endmodule

// File: tb/tb_snoop_write_port.sv
// tb/tb_snoop_write_port.sv - scoreboard bench for snoop_write_port
module tb_snoop_write_port;

    logic clk;
    logic reset;
    int   errors;
    int   checks;

    typedef struct {
        logic [29:0] a;
        logic [3:0]  be;
        logic [31:0] d;
    } exp_t;

    exp_t sbq[$];

    snoop_write_port_if bus ();

    snoop_write_port #(.DEPTH(4), .STARVE_MAX(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic sb_push(input logic [29:0] a, input logic [3:0] be, input logic [31:0] d);
        exp_t e;
        e.a = a; e.be = be; e.d = d;
        sbq.push_back(e);
    endtask

    // Drives one store for the next edge and returns at the following negedge.
    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3);
        bus.extAddr   = a;
        bus.extData   = d;
        bus.extFunct3 = f3;
        bus.extWren   = 1'b1;
        @(negedge clk);
    endtask

    task automatic ext_off();
        bus.extWren = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        sbq.delete();
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Monitor: every DMEM write must match the oldest expected store.
    always @(negedge clk) begin
        if (!reset && bus.memWren === 1'b1) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write actual addr=%h be=%b data=%h required=no write",
                         bus.memAddr, bus.memByteEn, bus.memData);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                check("wr_addr", {2'b00, bus.memAddr}, {2'b00, e.a});
                check("wr_byteen", {28'h0, bus.memByteEn}, {28'h0, e.be});
                check("wr_data", bus.memData, e.d);
            end
        end
    end

    initial begin
        int n;
        errors = 0;
        checks = 0;
        reset  = 1'b1;
        bus.extAddr = '0; bus.extData = '0; bus.extFunct3 = '0; bus.extWren = 1'b0;
        bus.locWren = 1'b0; bus.locRdAddr = '0; bus.locRden = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_memwren", {31'h0, bus.memWren}, 32'h0);
        check("rst_busy", {31'h0, bus.busy}, 32'h0);
        check("rst_forcestall", {31'h0, bus.forceStall}, 32'h0);
        check("rst_errflag", {31'h0, bus.errFlag}, 32'h0);
        check("rst_memaddr", {2'b00, bus.memAddr}, 32'h0);
        reset = 1'b0;

        // SB to 0x13: lane 3, one write two edges after capture.
        @(negedge clk);
        bus.extAddr = 32'h0000_0013; bus.extData = 32'h0000_00AB;
        bus.extFunct3 = 3'b000; bus.extWren = 1'b1;
        sb_push(30'h4, 4'b1000, 32'hABAB_ABAB);
        @(posedge clk); #1;
        bus.extWren = 1'b0;
        check("sb_lat_edge1", {31'h0, bus.memWren}, 32'h0);
        check("sb_busy", {31'h0, bus.busy}, 32'h1);
        @(posedge clk); #1;
        check("sb_lat_edge2", {31'h0, bus.memWren}, 32'h1);
        @(posedge clk); #1;
        check("sb_pulse_end", {31'h0, bus.memWren}, 32'h0);
        check("sb_drained", {31'h0, bus.busy}, 32'h0);

        // SH then SW on consecutive cycles.
        @(negedge clk);
        sb_push(30'h8, 4'b1100, 32'h1234_1234);
        store(32'h0000_0022, 32'h0000_1234, 3'b001);
        sb_push(30'h10, 4'b1111, 32'hDEAD_BEEF);
        store(32'h0000_0040, 32'hDEAD_BEEF, 3'b010);
        ext_off();
        repeat (5) @(negedge clk);
        check("shsw_all_written", sbq.size(), 32'h0);

        // Misaligned SH, then illegal funct3 after a reset.
        store(32'h0000_0021, 32'h0000_5555, 3'b001);
        ext_off();
        check("misalign_busy", {31'h0, bus.busy}, 32'h0);
        check("misalign_err", {31'h0, bus.errFlag}, 32'h1);
        do_reset();
        check("err_cleared", {31'h0, bus.errFlag}, 32'h0);
        @(negedge clk);
        store(32'h0000_0000, 32'h0000_0001, 3'b011);
        ext_off();
        check("illegal_busy", {31'h0, bus.busy}, 32'h0);
        check("illegal_err", {31'h0, bus.errFlag}, 32'h1);
        repeat (3) @(negedge clk);

        // Overflow and starvation with the local pipeline writing every cycle.
        do_reset();
        @(negedge clk);
        bus.locWren = 1'b1;
        sb_push(30'h80, 4'b1111, 32'h1111_0000);
        store(32'h0000_0200, 32'h1111_0000, 3'b010);
        sb_push(30'h81, 4'b1111, 32'h2222_0001);
        store(32'h0000_0204, 32'h2222_0001, 3'b010);
        sb_push(30'h82, 4'b0100, 32'h3333_3333);
        store(32'h0000_020A, 32'h0000_0033, 3'b000);
        sb_push(30'h83, 4'b0011, 32'h4444_4444);
        store(32'h0000_020C, 32'h0000_4444, 3'b001);
        store(32'h0000_0210, 32'h5555_5555, 3'b010);
        ext_off();
        check("ovf_err", {31'h0, bus.errFlag}, 32'h1);
        check("ovf_busy", {31'h0, bus.busy}, 32'h1);
        check("ovf_nostall_yet", {31'h0, bus.forceStall}, 32'h0);
        n = 0;
        while (n < 20 && bus.forceStall !== 1'b1) begin
            @(negedge clk);
            n++;
        end
        check("stall_rise_cycles", n, 32'd5);
        bus.locWren = 1'b0;
        n = 0;
        while (n < 20 && (bus.busy !== 1'b0 || bus.forceStall !== 1'b0)) begin
            @(negedge clk);
            n++;
        end
        check("stall_fall_in_time", {31'h0, (n < 20)}, 32'h1);
        check("stall_low", {31'h0, bus.forceStall}, 32'h0);
        check("ovf_drained_all", sbq.size(), 32'h0);

        // Load hit against a pending SW.
        @(negedge clk);
        bus.locWren = 1'b1;
        sb_push(30'h40, 4'b1111, 32'hCAFE_F00D);
        store(32'h0000_0100, 32'hCAFE_F00D, 3'b010);
        ext_off();
        bus.locRden = 1'b1;
        bus.locRdAddr = 32'h0000_0102; #1;
        check("rdhit_same_word", {31'h0, bus.rdHit}, 32'h1);
        bus.locRdAddr = 32'h0000_0104; #1;
        check("rdhit_next_word", {31'h0, bus.rdHit}, 32'h0);
        bus.locRden = 1'b0;
        bus.locRdAddr = 32'h0000_0100; #1;
        check("rdhit_no_rden", {31'h0, bus.rdHit}, 32'h0);
        @(negedge clk);
        bus.locWren = 1'b0;
        repeat (4) @(negedge clk);
        check("hit_entry_written", sbq.size(), 32'h0);

        // Reset with entries pending and a write in flight.
        bus.locWren = 1'b1;
        store(32'h0000_0300, 32'hA0A0_A0A0, 3'b010);
        store(32'h0000_0304, 32'hB0B0_B0B0, 3'b010);
        store(32'h0000_0308, 32'hC0C0_C0C0, 3'b010);
        ext_off();
        check("pre_rst_busy", {31'h0, bus.busy}, 32'h1);
        check("pre_rst_err", {31'h0, bus.errFlag}, 32'h1);
        bus.locWren = 1'b0;
        @(posedge clk); #1;
        check("pre_rst_inflight", {31'h0, bus.memWren}, 32'h1);
        #1 reset = 1'b1;
        #1;
        check("async_rst_memwren", {31'h0, bus.memWren}, 32'h0);
        check("async_rst_busy", {31'h0, bus.busy}, 32'h0);
        check("async_rst_forcestall", {31'h0, bus.forceStall}, 32'h0);
        check("async_rst_errflag", {31'h0, bus.errFlag}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        check("post_rst_busy", {31'h0, bus.busy}, 32'h0);
        check("final_queue_empty", sbq.size(), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
